// File: rtl/conv_pkg.sv
// Shared constants and state type for the 1-D convolution compute side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int DATA_N_DEF    = 8;
  localparam int LG_DATA_N_DEF = 3;
  localparam int FILT_N_DEF    = 4;
  localparam int LG_FILT_N_DEF = 2;
  localparam int DW_DEF        = 8;

  // Results per frame and result width for the default geometry.
  // OUT_W leaves LG_FILT_N guard bits so FILT_N full-scale products cannot overflow.
  localparam int N_OUT = DATA_N_DEF - FILT_N_DEF + 1;
  localparam int OUT_W = 2 * DW_DEF + LG_FILT_N_DEF;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_MAC   = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: acc = load ? a*b : acc + a*b, product sign-extended to OUT_W.
// Latency: accumulator updates on the clock edge after en is sampled high.
// Backpressure: none; en gates every update, acc holds when en is low.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int LG_FILT_N = LG_FILT_N_DEF,
  parameter int OUT_W     = 2 * DW + LG_FILT_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [OUT_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [OUT_W-1:0] prod_ext;
  logic signed [OUT_W-1:0] acc_q, acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(OUT_W-2*DW){prod[2*DW-1]}}, prod};

  // Tap 0 starts a fresh sum; later taps add onto it.
  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = load ? prod_ext : acc_q + prod_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_compute_ctrl.sv
// Compute controller: waits for both buffers loaded, then y[n] = sum_k x[n+k]*f[k] per output.
// Latency: first y valid FILT_N+2 cycles after leaving S_LOAD; FILT_N+2 cycles per result.
// Backpressure: y held stable in S_OUT until m_ready_y; no reads are issued while stalled.
module conv_compute_ctrl
#(
  parameter int DATA_N    = conv_pkg::DATA_N_DEF,
  parameter int LG_DATA_N = conv_pkg::LG_DATA_N_DEF,
  parameter int FILT_N    = conv_pkg::FILT_N_DEF,
  parameter int LG_FILT_N = conv_pkg::LG_FILT_N_DEF,
  parameter int DW        = conv_pkg::DW_DEF,
  parameter int OUT_W     = 2 * DW + LG_FILT_N
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_x,
  input  logic                    done_f,
  output logic                    mem_wr_state,
  output logic                    mem_wr_done,
  output logic [LG_DATA_N-1:0]    rd_addr_x,
  output logic [LG_FILT_N-1:0]    rd_addr_f,
  input  logic signed [DW-1:0]    rd_data_x,
  input  logic signed [DW-1:0]    rd_data_f,
  output logic signed [OUT_W-1:0] m_data_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  import conv_pkg::*;

  localparam logic [LG_FILT_N-1:0] K_LAST = LG_FILT_N'(FILT_N - 1);
  localparam logic [LG_DATA_N-1:0] N_LAST = LG_DATA_N'(DATA_N - FILT_N);

  state_e               state_q, state_d;
  logic [LG_DATA_N-1:0] n_q, n_d;
  logic [LG_FILT_N-1:0] k_q, k_d;
  logic                 rd_vld_q;
  logic                 rd_first_q;

  // Sequencing: load wait, FILT_N read issues, one drain cycle, output handshake, rearm pulse.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      S_LOAD: begin
        if (done_x && done_f) state_d = S_MAC;
      end
      S_MAC: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + LG_FILT_N'(1);
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT: begin
        if (m_ready_y) begin
          if (n_q == N_LAST) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + LG_DATA_N'(1);
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        n_d     = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  // Read-return tracking: memory data arrives one cycle after the address, so flag it then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      rd_vld_q   <= (state_q == S_MAC);
      rd_first_q <= (state_q == S_MAC) && (k_q == '0);
    end
  end

  conv_mac #(
    .DW        (DW),
    .LG_FILT_N (LG_FILT_N),
    .OUT_W     (OUT_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en    (rd_vld_q),
    .load  (rd_first_q),
    .a     (rd_data_x),
    .b     (rd_data_f),
    .acc   (m_data_y)
  );

  // Addresses come straight from the counters; k is 0 outside S_MAC so they sit still while stalled.
  assign rd_addr_x    = n_q + LG_DATA_N'(k_q);
  assign rd_addr_f    = k_q;
  assign mem_wr_state = (state_q == S_LOAD);
  assign mem_wr_done  = (state_q == S_DONE);
  assign m_valid_y    = (state_q == S_OUT);

endmodule

// File: tb/tb_conv_compute_ctrl.sv
module tb_conv_compute_ctrl;

  localparam int DATA_N = 8;
  localparam int FILT_N = 4;
  localparam int N_OUT  = DATA_N - FILT_N + 1;
  localparam int OUT_W  = 18;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    done_x, done_f;
  logic                    mem_wr_state, mem_wr_done;
  logic [2:0]              rd_addr_x;
  logic [1:0]              rd_addr_f;
  logic signed [7:0]       rd_data_x, rd_data_f;
  logic signed [OUT_W-1:0] m_data_y;
  logic                    m_valid_y, m_ready_y;

  logic signed [7:0] x_mem [DATA_N];
  logic signed [7:0] f_mem [FILT_N];
  int                x_v   [DATA_N];
  int                f_v   [FILT_N];
  longint            y_exp [N_OUT];

  int n_chk  = 0;
  int n_pass = 0;

  conv_compute_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .done_x       (done_x),
    .done_f       (done_f),
    .mem_wr_state (mem_wr_state),
    .mem_wr_done  (mem_wr_done),
    .rd_addr_x    (rd_addr_x),
    .rd_addr_f    (rd_addr_f),
    .rd_data_x    (rd_data_x),
    .rd_data_f    (rd_data_f),
    .m_data_y     (m_data_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model: data one cycle after address.
  always @(posedge clk) begin
    rd_data_x <= x_mem[rd_addr_x];
    rd_data_f <= f_mem[rd_addr_f];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: load vectors into memory and compute the convolution directly.
  task automatic prepare();
    for (int i = 0; i < DATA_N; i++) x_mem[i] = 8'(x_v[i]);
    for (int i = 0; i < FILT_N; i++) f_mem[i] = 8'(f_v[i]);
    for (int n = 0; n < N_OUT; n++) begin
      longint s = 0;
      for (int k = 0; k < FILT_N; k++) s += longint'(x_v[n+k]) * longint'(f_v[k]);
      y_exp[n] = s;
    end
  endtask

  task automatic load_frame(input int skew);
    @(negedge clk);
    chk("ld_wr_state", mem_wr_state, 1);
    done_x = 1'b1;
    for (int i = 0; i < skew; i++) begin
      @(negedge clk);
      chk("skew_wr_state", mem_wr_state, 1);
      chk("skew_addr", rd_addr_x, 0);
      chk("skew_vld", m_valid_y, 0);
    end
    done_f = 1'b1;
    @(posedge clk);
  endtask

  // mode 0: ready high; 1: random ready; 2: stall 3 cycles on the 2nd result.
  task automatic run_frame(input int mode, input bit timing);
    int got = 0, cyc = 0, last = -1, done_cnt = 0, stall = 0;
    bit pv = 1'b0;
    longint pd = 0;
    longint pa = 0;
    while (got < N_OUT && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      done_x = 1'b0;
      done_f = 1'b0;
      if (cyc == 1) chk("compute_wr_state", mem_wr_state, 0);
      if (mem_wr_done) done_cnt++;
      if (pv) begin
        chk("hold_vld", m_valid_y, 1);
        chk("hold_dat", $signed(m_data_y), pd);
        chk("hold_addr", rd_addr_x, pa);
      end
      case (mode)
        1: m_ready_y = 1'($urandom_range(0, 1));
        2: begin
          if (got == 1 && m_valid_y && stall < 3) begin
            m_ready_y = 1'b0;
            stall++;
          end else m_ready_y = 1'b1;
        end
        default: m_ready_y = 1'b1;
      endcase
      if (m_valid_y && m_ready_y) begin
        chk($sformatf("y%0d", got), $signed(m_data_y), y_exp[got]);
        if (timing) chk(got == 0 ? "latency" : "period", cyc - last, got == 0 ? FILT_N + 2 : FILT_N + 2);
        last = cyc;
        got++;
      end
      if (got == 0 && last < 0 && timing) last = 0;
      pv = m_valid_y && !m_ready_y;
      pd = $signed(m_data_y);
      pa = rd_addr_x;
    end
    chk("result_count", got, N_OUT);
    chk("early_done", done_cnt, 0);
    if (mode == 2) chk("stall_cycles", stall, 3);
    @(negedge clk);
    chk("done_pulse", mem_wr_done, 1);
    chk("done_wr_state", mem_wr_state, 0);
    chk("done_vld", m_valid_y, 0);
    @(negedge clk);
    chk("done_single", mem_wr_done, 0);
    chk("rearm_wr_state", mem_wr_state, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_state"}, mem_wr_state, 1);
    chk({tag, "_wr_done"}, mem_wr_done, 0);
    chk({tag, "_vld"}, m_valid_y, 0);
    chk({tag, "_dat"}, $signed(m_data_y), 0);
    chk({tag, "_addr_x"}, rd_addr_x, 0);
    chk({tag, "_addr_f"}, rd_addr_f, 0);
  endtask

  initial begin
    reset     = 1'b1;
    done_x    = 1'b0;
    done_f    = 1'b0;
    m_ready_y = 1'b0;
    for (int i = 0; i < DATA_N; i++) x_mem[i] = '0;
    for (int i = 0; i < FILT_N; i++) f_mem[i] = '0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic ramp with unit filter, timing checked.
    for (int i = 0; i < DATA_N; i++) x_v[i] = i + 1;
    for (int i = 0; i < FILT_N; i++) f_v[i] = 1;
    prepare();
    load_frame(0);
    run_frame(0, 1'b1);

    // Signed extremes.
    for (int i = 0; i < DATA_N; i++) x_v[i] = -128;
    for (int i = 0; i < FILT_N; i++) f_v[i] = -128;
    prepare();
    load_frame(0);
    run_frame(0, 1'b1);

    for (int i = 0; i < DATA_N; i++) x_v[i] = i + 1;
    f_v[0] = -1; f_v[1] = 0; f_v[2] = 0; f_v[3] = 0;
    prepare();
    load_frame(0);
    run_frame(0, 1'b0);

    // Backpressure on the second result.
    for (int i = 0; i < FILT_N; i++) f_v[i] = 1;
    prepare();
    load_frame(0);
    run_frame(2, 1'b0);

    // done_x leads done_f by 5 cycles.
    load_frame(5);
    run_frame(0, 1'b1);

    // Reset during the third compute cycle abandons the frame.
    load_frame(0);
    repeat (3) @(negedge clk);
    done_x = 1'b0;
    done_f = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    begin
      int spurious = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_wr_done || m_valid_y || !mem_wr_state) spurious++;
      end
      chk("midrst_quiet", spurious, 0);
    end
    load_frame(0);
    run_frame(0, 1'b1);

    // Back-to-back frame with a new pattern.
    for (int i = 0; i < DATA_N; i++) x_v[i] = DATA_N - i;
    for (int i = 0; i < FILT_N; i++) f_v[i] = i + 1;
    prepare();
    load_frame(0);
    run_frame(0, 1'b1);

    // Random data, random skew, random downstream ready.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DATA_N; i++) x_v[i] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < FILT_N; i++) f_v[i] = int'($urandom_range(0, 255)) - 128;
      prepare();
      load_frame(int'($urandom_range(0, 3)));
      run_frame(1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
